// File: rtl/flasher_seq_ctrl.sv
// Bound-flasher sequencer: walks a thermometer lamp bar toward a table of limits,
// one bit per cycle, with optional per-entry kick-backs capped per run.
module flasher_seq_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int MAX_KICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_kick_en,
  input  logic [AW-1:0]    cfg_kick_tgt,
  input  logic [AW-1:0]    cfg_last,
  input  logic             start,
  input  logic             abort,
  input  logic             flick,
  output logic [WIDTH-1:0] lamp,
  output logic [AW-1:0]    stage,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int KW = $clog2(MAX_KICKS + 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_ADVANCE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] lamp_reg, lamp_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic [AW-1:0]    stage_reg, stage_next;
  logic [AW-1:0]    last_reg, last_next;
  logic [KW-1:0]    kick_cnt_reg, kick_cnt_next;
  logic             busy_reg, done_reg, cfg_err_reg;
  logic             done_next, cfg_err_next;

  logic [WIDTH-1:0] tbl_limit    [DEPTH];
  logic             tbl_kick_en  [DEPTH];
  logic [AW-1:0]    tbl_kick_tgt [DEPTH];

  logic [AW-1:0]    last_in, kick_tgt_in;
  logic             cfg_therm, cfg_accept;

  function automatic logic [WIDTH-1:0] default_limit(input int idx);
    logic [15:0] v;
    case (idx % 8)
      0:       v = 16'h003F;
      2:       v = 16'h07FF;
      3:       v = 16'h001F;
      4:       v = 16'hFFFF;
      6:       v = 16'hFFFF;
      default: v = 16'h0000;
    endcase
    return WIDTH'(v);
  endfunction

  // Out-of-range indices only exist when DEPTH is not a power of two.
  if (DEPTH < (1 << AW)) begin : g_clamp
    assign last_in     = (cfg_last > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : cfg_last;
    assign kick_tgt_in = (cfg_kick_tgt > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : cfg_kick_tgt;
  end else begin : g_noclamp
    assign last_in     = cfg_last;
    assign kick_tgt_in = cfg_kick_tgt;
  end

  // A thermometer code plus one has no bits in common with itself.
  assign cfg_therm    = ((cfg_data & (cfg_data + WIDTH'(1))) == '0);
  assign cfg_accept   = cfg_we && (state_reg == S_IDLE) && cfg_therm;
  assign cfg_err_next = cfg_we && !cfg_accept;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        tbl_limit[i]    <= default_limit(i);
        tbl_kick_en[i]  <= 1'b0;
        tbl_kick_tgt[i] <= '0;
      end else if (cfg_accept && (cfg_addr == AW'(i))) begin
        tbl_limit[i]    <= cfg_data;
        tbl_kick_en[i]  <= cfg_kick_en;
        tbl_kick_tgt[i] <= kick_tgt_in;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    lamp_next     = lamp_reg;
    limit_next    = limit_reg;
    stage_next    = stage_reg;
    last_next     = last_reg;
    kick_cnt_next = kick_cnt_reg;
    done_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LOAD;
          stage_next    = '0;
          kick_cnt_next = '0;
          last_next     = last_in;
        end
      end
      S_LOAD: begin
        limit_next = tbl_limit[stage_reg];
        state_next = S_STEP;
      end
      S_STEP: begin
        if (lamp_reg < limit_reg) begin
          lamp_next = {lamp_reg[WIDTH-2:0], 1'b1};
        end else if (lamp_reg > limit_reg) begin
          lamp_next = lamp_reg >> 1;
        end else begin
          state_next = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (flick && tbl_kick_en[stage_reg] && (kick_cnt_reg < KW'(MAX_KICKS))) begin
          stage_next    = tbl_kick_tgt[stage_reg];
          kick_cnt_next = kick_cnt_reg + 1'b1;
          state_next    = S_LOAD;
        end else if (stage_reg == last_reg) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          stage_next = stage_reg + 1'b1;
          state_next = S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides everything, including a completion in the same cycle.
    if ((state_reg != S_IDLE) && abort) begin
      state_next = S_IDLE;
      lamp_next  = '0;
      stage_next = '0;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      lamp_reg     <= '0;
      limit_reg    <= '0;
      stage_reg    <= '0;
      last_reg     <= AW'(DEPTH - 1);
      kick_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lamp_reg     <= lamp_next;
      limit_reg    <= limit_next;
      stage_reg    <= stage_next;
      last_reg     <= last_next;
      kick_cnt_reg <= kick_cnt_next;
      busy_reg     <= (state_next != S_IDLE);
      done_reg     <= done_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  assign lamp    = lamp_reg;
  assign stage   = stage_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_flasher_seq_ctrl.sv
// Bench for flasher_seq_ctrl: a run-trajectory model checked every cycle, plus
// directed runs whose totals and stage orders are pinned to hand-computed numbers.
module tb_flasher_seq_ctrl;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int MAX_KICKS = 4;

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_kick_en, start, abort, flick;
  logic [AW-1:0]    cfg_addr, cfg_kick_tgt, cfg_last;
  logic [WIDTH-1:0] cfg_data;
  logic [WIDTH-1:0] lamp;
  logic [AW-1:0]    stage;
  logic             busy, done, cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flasher_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .MAX_KICKS(MAX_KICKS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_kick_en(cfg_kick_en), .cfg_kick_tgt(cfg_kick_tgt), .cfg_last(cfg_last),
    .start(start), .abort(abort), .flick(flick),
    .lamp(lamp), .stage(stage), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- model: whole-run trajectory of outputs, one entry per edge
  typedef struct {
    logic [WIDTH-1:0] lamp;
    int               stage;
    bit               busy;
    bit               done;
  } exp_t;

  exp_t             traj[$];
  logic [WIDTH-1:0] m_lim  [DEPTH];
  bit               m_ken  [DEPTH];
  int               m_ktgt [DEPTH];
  logic [WIDTH-1:0] e_lamp = '0;
  int               e_stage = 0;
  bit               e_busy = 0, e_done = 0, e_err = 0;

  function automatic logic [WIDTH-1:0] therm(input int k);
    return WIDTH'((64'd1 << k) - 64'd1);
  endfunction

  function automatic bit is_therm(input logic [WIDTH-1:0] v);
    return v == therm($countones(v));
  endfunction

  function automatic void model_defaults();
    m_lim = '{16'h003F, 16'h0000, 16'h07FF, 16'h001F, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    for (int i = 0; i < DEPTH; i++) begin
      m_ken[i]  = 1'b0;
      m_ktgt[i] = 0;
    end
  endfunction

  function automatic void push_exp(input int k, input int s, input bit b, input bit d);
    exp_t t;
    t.lamp  = therm(k);
    t.stage = s;
    t.busy  = b;
    t.done  = d;
    traj.push_back(t);
  endfunction

  // Lamp is tracked as a count of lit bits; each stage is: load, walk, settle, decide.
  function automatic void build_run(input int last, input bit flk);
    int k, s, kicks, goal;
    bit fin;
    k = $countones(e_lamp);
    s = 0;
    kicks = 0;
    fin = 0;
    push_exp(k, 0, 1, 0);
    while (!fin) begin
      push_exp(k, s, 1, 0);
      goal = $countones(m_lim[s]);
      while (k != goal) begin
        k = (k < goal) ? k + 1 : k - 1;
        push_exp(k, s, 1, 0);
      end
      push_exp(k, s, 1, 0);
      if (flk && m_ken[s] && kicks < MAX_KICKS) begin
        kicks++;
        s = m_ktgt[s];
        push_exp(k, s, 1, 0);
      end else if (s == last) begin
        push_exp(k, s, 0, 1);
        fin = 1;
      end else begin
        s++;
        push_exp(k, s, 1, 0);
      end
    end
  endfunction

  function automatic void model_step();
    bit   busy_pre;
    exp_t t;
    busy_pre = traj.size() > 0;
    e_done = 0;
    if (rst) begin
      traj.delete();
      model_defaults();
      e_lamp = '0;
      e_stage = 0;
      e_busy = 0;
      e_err = 0;
    end else begin
      e_err = cfg_we && (busy_pre || !is_therm(cfg_data));
      if (cfg_we && !busy_pre && is_therm(cfg_data)) begin
        m_lim[cfg_addr]  = cfg_data;
        m_ken[cfg_addr]  = cfg_kick_en;
        m_ktgt[cfg_addr] = int'(cfg_kick_tgt);
      end
      if (busy_pre && abort) begin
        traj.delete();
        e_lamp = '0;
        e_stage = 0;
        e_busy = 0;
      end else begin
        if (!busy_pre && start) build_run(int'(cfg_last), flick);
        if (traj.size() > 0) begin
          t = traj.pop_front();
          e_lamp = t.lamp;
          e_stage = t.stage;
          e_busy = t.busy;
          e_done = t.done;
        end else begin
          e_busy = 0;
        end
      end
    end
  endfunction

  // Per-cycle compare against the model, one step after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cyc_lamp", 32'(lamp), 32'(e_lamp));
      check("cyc_stage", 32'(stage), 32'(e_stage));
      check("cyc_busy", 32'(busy), 32'(e_busy));
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_cfg_err", 32'(cfg_err), 32'(e_err));
    end
  end

  // ---------------- directed stimulus
  int w_chg, w_done, w_busy, w_err;
  int seen_stages[$];
  int exp_q[$];

  task automatic check_seq(input string name, input int want[$]);
    check({name, "_len"}, 32'(seen_stages.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < seen_stages.size(); i++)
      check(name, 32'(seen_stages[i]), 32'(want[i]));
  endtask

  // Caller drives the run request before calling; this watches until the run ends.
  task automatic run_watch(input string name, input int start_at, input int poke_at,
                           input int abort_lamp, input int rst_at);
    logic [WIDTH-1:0] prev;
    int  n, tail;
    bit  fin;
    prev = lamp;
    n = 0;
    tail = -1;
    fin = 0;
    w_chg = 0; w_done = 0; w_busy = 0; w_err = 0;
    seen_stages.delete();
    while (!fin && n < 1000) begin
      @(negedge clk);
      n++;
      start = 0; abort = 0; cfg_we = 0; rst = 0;
      if (lamp !== prev) w_chg++;
      prev = lamp;
      if (busy) w_busy++;
      if (done) w_done++;
      if (cfg_err) w_err++;
      if (busy && (seen_stages.size() == 0 || seen_stages[$] != int'(stage)))
        seen_stages.push_back(int'(stage));
      if (!busy && tail < 0) tail = 3;
      if (tail == 0) fin = 1;
      else if (tail > 0) tail--;
      if (n == start_at) start = 1;
      if (n == poke_at) begin
        cfg_we = 1; cfg_addr = '0; cfg_data = '0; cfg_kick_en = 0; cfg_kick_tgt = '0;
      end
      if (abort_lamp >= 0 && busy && stage == 3'd2 && lamp == abort_lamp[WIDTH-1:0]) abort = 1;
      if (n == rst_at) rst = 1;
    end
    check({name, "_ends"}, 32'(fin), 32'd1);
    $display("[TB] run %s: %0d cycles, %0d lamp changes, busy %0d, done %0d, cfg_err %0d, stages %0d",
             name, n, w_chg, w_busy, w_done, w_err, seen_stages.size());
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; flick = 0; cfg_we = 0; cfg_addr = '0;
    cfg_data = '0; cfg_kick_en = 0; cfg_kick_tgt = '0; cfg_last = 3'd7;
    repeat (2) @(negedge clk);
    check("rst_lamp", 32'(lamp), 32'h0);
    check("rst_stage", 32'(stage), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    rst = 0;
    @(negedge clk);

    // 1: default table, full run
    start = 1;
    run_watch("defaults", -1, -1, -1, -1);
    check("t1_changes", 32'(w_chg), 32'd88);
    check("t1_busy", 32'(w_busy), 32'd112);
    check("t1_done", 32'(w_done), 32'd1);
    check("t1_lamp", 32'(lamp), 32'h0000);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("t1_stages", exp_q);

    // 2: entry 2 kicks back to 1, flick held
    cfg_we = 1; cfg_addr = 3'd2; cfg_data = 16'h07FF; cfg_kick_en = 1; cfg_kick_tgt = 3'd1;
    @(negedge clk);
    cfg_we = 0;
    check("t2_write_ok", 32'(cfg_err), 32'h0);
    flick = 1;
    start = 1;
    run_watch("kicks", -1, -1, -1, -1);
    flick = 0;
    check("t2_changes", 32'(w_chg), 32'd176);
    check("t2_done", 32'(w_done), 32'd1);
    exp_q = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 3, 4, 5, 6, 7};
    check_seq("t2_stages", exp_q);

    // 3: rejected writes
    cfg_we = 1; cfg_addr = 3'd3; cfg_data = 16'h00F0; cfg_kick_en = 0; cfg_kick_tgt = '0;
    @(negedge clk);
    cfg_we = 0;
    check("t3_err_pulse", 32'(cfg_err), 32'h1);
    @(negedge clk);
    check("t3_err_clear", 32'(cfg_err), 32'h0);
    start = 1;
    run_watch("busy_write", -1, 40, -1, -1);
    check("t3_busy_err", 32'(w_err), 32'd1);
    check("t3_changes", 32'(w_chg), 32'd88);
    check("t3_done", 32'(w_done), 32'd1);

    // 4: abort at lamp 00FF in stage 2
    start = 1;
    run_watch("abort", -1, -1, 32'h00FF, -1);
    check("t4_done", 32'(w_done), 32'd0);
    check("t4_lamp", 32'(lamp), 32'h0000);
    check("t4_stage", 32'(stage), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);

    // 5: reset mid-run, then a rerun proves the table defaults are back
    flick = 1;
    start = 1;
    run_watch("reset", -1, -1, -1, 20);
    check("t5_done", 32'(w_done), 32'd0);
    check("t5_lamp", 32'(lamp), 32'h0000);
    check("t5_stage", 32'(stage), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    start = 1;
    run_watch("rerun", -1, -1, -1, -1);
    check("t5_changes", 32'(w_chg), 32'd88);
    check("t5_rerun_done", 32'(w_done), 32'd1);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("t5_stages", exp_q);
    flick = 0;

    // 6: start while busy ignored; start+abort in idle; single-stage run
    start = 1;
    run_watch("restart", 30, -1, -1, -1);
    check("t6_changes", 32'(w_chg), 32'd88);
    check("t6_done", 32'(w_done), 32'd1);
    cfg_last = 3'd0;
    start = 1;
    abort = 1;
    run_watch("single", -1, -1, -1, -1);
    cfg_last = 3'd7;
    check("t6s_busy", 32'(w_busy), 32'd9);
    check("t6s_changes", 32'(w_chg), 32'd6);
    check("t6s_lamp", 32'(lamp), 32'h003F);
    check("t6s_done", 32'(w_done), 32'd1);
    exp_q = '{0};
    check_seq("t6s_stages", exp_q);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
